seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Reads a multiplexed, active-low seven-segment display bus (one-hot digit strobe plus shared segment lines) and recovers the hexadecimal value being shown. It is the reader side of our hex-to-segment display path. It sits on the board-test and self-check path, tapping the scan outputs that drive the HEX displays. It requires each digit's pattern to be stable for a programmable dwell, decodes it, assembles a full frame, and reports the frame with a one-cycle valid pulse and an error flag.

## Interface
- NDIGITS, 4: number of scanned digits (1–8).
- STABLE, 3: consecutive identical samples required before a digit is captured (1–15).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- digit_en  in  NDIGITS  digit strobe, active-high, one-hot; all-zero means blanking.
- seg  in  8  active-low segments; bit 7 = DP, bits 6:0 = g..a.
- value  out  4*NDIGITS  last complete frame; digit i in bits [4i+3:4i].
- dp  out  NDIGITS  decimal-point state per digit for the last frame (1 = lit).
- frame_valid  out  1  one-cycle pulse when value/dp/err update.
- err  out  1  last frame contained an invalid pattern or non-one-hot strobe; held until the next frame.

## Operation
- Input stage: digit_en and seg are registered every cycle into the sample s_k. All decisions use registered samples.
- Decode is an exact match of bits 6:0 against 16 patterns (hex, bits 6:0):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, B:03, C:46, D:21, E:06, F:0E
- Any other pattern is invalid. Bit 7 is ignored for decode and stored as dp = ~seg[7].
- Dwell FSM, states BLANK, SETTLE, HELD:
  - BLANK: s_k strobe all-zero. Counter is 0. No error.
  - If the strobe is multi-hot in any state: go to BLANK and set frame_err.
  - One-hot s_k different from s_{k-1}, or first after BLANK: go to SETTLE with count = 1.
  - In SETTLE, each identical sample increments the count. When count reaches STABLE, capture the digit and go to HELD. If STABLE = 1, capture on the first sample.
  - HELD: identical samples do nothing, so there is no second capture in the same dwell. Any change is handled as above.
- Capture writes the nibble (4'h0 if invalid, and sets frame_err) and the dp bit into slot i, and sets captured[i]. Re-capturing the same digit within a frame overwrites the slot.
- Frame complete (captured all ones, including the capture on this edge):
  - At the next edge, value and dp take the slot contents.
  - err takes frame_err, including an error raised on the completing edge.
  - frame_valid pulses.
  - captured and frame_err clear.
- Reset mid-frame discards the partial frame. No frame_valid is produced.

## Timing
- Reset values: value 0, dp 0, frame_valid 0, err 0, captured 0, frame_err 0, FSM in BLANK, input register 0.
- Latency: a completing digit presented at the ports from cycle t, steady, gives frame_valid high in cycle t+STABLE+1. value/dp/err are valid in that same cycle.
- frame_valid is never high for two consecutive cycles.
- value/dp/err change only on a frame_valid edge or on reset.
- Strobe glitches shorter than STABLE cycles never cause a capture.

## Structure
- Package seg7_pkg holds:
  - the 16-entry segment pattern constant (logic [6:0]), shared with the existing hex-to-segment encoder;
  - the dwell-state enum typedef.
- Sub-module seg7_pattern_to_hex: combinational. Takes a 7-bit pattern in; gives a 4-bit nibble and a valid flag out. It is instantiated once on the registered sample.

## Test plan
- Show digits 0..3 with patterns 40,79,24,30 (bit7 = 1), each held 4 cycles, STABLE = 3 -> one frame_valid; value = 16'h3210, dp = 0, err = 0.
- Show A,B,C,D (08,03,46,21) with DP lit (bit7 = 0) on digit 2 -> value = 16'hDCBA, dp = 4'b0100.
- Digit 1 with pattern 7F (blank) in an otherwise valid frame -> frame_valid; err = 1; nibble 1 = 0. The next clean frame returns err = 0.
- Digit 0 held only 2 cycles (STABLE = 3), plus a strobe of 4'b0011 for 1 cycle -> no capture of that dwell; the multi-hot strobe sets err for the frame.
- Assert reset after 3 of 4 digits captured, then scan a full frame -> no pulse before reset; all outputs 0 during reset; exactly one pulse after with the new frame.
- Hold digit 3 steady for 50 cycles after completion -> no further capture or frame_valid until other digits are rescanned.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan path.
// Holds the active-low segment patterns for hex digits 0..F (bits 6:0 = g..a),
// common with the hex-to-segment encoder, and the dwell-state encoding.
package seg7_pkg;

    localparam int unsigned NUM_PATTERNS = 16;

    // Index is the hex value shown; entry is the active-low g..a pattern.
    localparam logic [6:0] SEG_PATTERNS [NUM_PATTERNS] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        DW_BLANK  = 2'd0,
        DW_SETTLE = 2'd1,
        DW_HELD   = 2'd2
    } dwell_state_t;

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse lookup of a seven-segment pattern.
// Ports:
//   pattern  - active-low g..a segment pattern
//   nibble_c - hex value whose pattern matches exactly (0 when no match)
//   valid_c  - high when the pattern is one of the 16 hex patterns
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble_c,
    output logic       valid_c
);

    // Patterns are unique, so at most one entry can match.
    always_comb begin
        nibble_c = 4'h0;
        valid_c  = 1'b0;
        for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
            if (pattern == SEG_PATTERNS[i]) begin
                nibble_c = 4'(i);
                valid_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex frame shown on a multiplexed active-low 7-segment bus.
// Each digit must dwell unchanged for STABLE samples before it is captured;
// when every digit has been captured the frame is published with a pulse.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   digit_en    - one-hot digit strobe (all-zero = blanking)
//   seg         - active-low segments, bit 7 = DP, bits 6:0 = g..a
//   value       - last complete frame, digit i in [4i+3:4i]
//   dp          - decimal points of the last frame (1 = lit)
//   frame_valid - one-cycle pulse when value/dp/err update
//   err         - last frame had an invalid pattern or a multi-hot strobe
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned STABLE  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NDIGITS-1:0]     digit_en,
    input  logic [7:0]             seg,
    output logic [4*NDIGITS-1:0]   value,
    output logic [NDIGITS-1:0]     dp,
    output logic                   frame_valid,
    output logic                   err
);

    localparam int unsigned CW = 4;

    logic [NDIGITS-1:0]   s_en, p_en;
    logic [7:0]           s_seg, p_seg;
    dwell_state_t         state, state_nxt;
    logic [CW-1:0]        count, count_nxt, cnt_inc_c;
    logic                 capture_c, strobe_err_c, same_c;
    logic [3:0]           dec_nibble_c;
    logic                 dec_valid_c;
    logic [4*NDIGITS-1:0] slot_val, slot_val_nxt;
    logic [NDIGITS-1:0]   slot_dp, slot_dp_nxt;
    logic [NDIGITS-1:0]   captured, captured_nxt;
    logic                 frame_err, frame_err_nxt;
    logic                 complete_c;

    seg7_pattern_to_hex u_decode (
        .pattern  (s_seg[6:0]),
        .nibble_c (dec_nibble_c),
        .valid_c  (dec_valid_c)
    );

    // Input sample s_k and the previous sample s_{k-1}.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_en  <= '0;
            s_seg <= '0;
            p_en  <= '0;
            p_seg <= '0;
        end else begin
            s_en  <= digit_en;
            s_seg <= seg;
            p_en  <= s_en;
            p_seg <= s_seg;
        end
    end

    // Dwell state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DW_BLANK;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Dwell next-state: restart on any change, capture once when count hits STABLE.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        capture_c    = 1'b0;
        strobe_err_c = 1'b0;
        cnt_inc_c    = count + CW'(1);
        same_c       = (s_en == p_en) && (s_seg == p_seg);
        if (s_en == '0) begin
            state_nxt = DW_BLANK;
            count_nxt = '0;
        end else if (!$onehot(s_en)) begin
            state_nxt    = DW_BLANK;
            count_nxt    = '0;
            strobe_err_c = 1'b1;
        end else if ((state == DW_BLANK) || !same_c) begin
            count_nxt = CW'(1);
            if (STABLE == 1) begin
                capture_c = 1'b1;
                state_nxt = DW_HELD;
            end else begin
                state_nxt = DW_SETTLE;
            end
        end else if (state == DW_SETTLE) begin
            count_nxt = cnt_inc_c;
            if (cnt_inc_c == CW'(STABLE)) begin
                capture_c = 1'b1;
                state_nxt = DW_HELD;
            end
        end
    end

    // Frame assembly: merge this edge's capture so completion sees it.
    always_comb begin
        slot_val_nxt  = slot_val;
        slot_dp_nxt   = slot_dp;
        captured_nxt  = captured;
        frame_err_nxt = frame_err | strobe_err_c;
        if (capture_c) begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                if (s_en[i]) begin
                    slot_val_nxt[4*i +: 4] = dec_valid_c ? dec_nibble_c : 4'h0;
                    slot_dp_nxt[i]         = ~s_seg[7];
                    captured_nxt[i]        = 1'b1;
                end
            end
            if (!dec_valid_c) begin
                frame_err_nxt = 1'b1;
            end
        end
        complete_c = &captured_nxt;
    end

    // Slot storage and published frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_val    <= '0;
            slot_dp     <= '0;
            captured    <= '0;
            frame_err   <= 1'b0;
            value       <= '0;
            dp          <= '0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            slot_val <= slot_val_nxt;
            slot_dp  <= slot_dp_nxt;
            if (complete_c) begin
                value       <= slot_val_nxt;
                dp          <= slot_dp_nxt;
                err         <= frame_err_nxt;
                frame_valid <= 1'b1;
                captured    <= '0;
                frame_err   <= 1'b0;
            end else begin
                frame_valid <= 1'b0;
                captured    <= captured_nxt;
                frame_err   <= frame_err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a run-length reference model
// predicts each published frame; a negedge monitor pops and compares.
module tb_seg7_scan_decoder;

    localparam int unsigned ND  = 4;
    localparam int unsigned STB = 3;

    localparam logic [6:0] TB_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic        e;
        int          edge_no;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [ND-1:0] digit_en;
    logic [7:0]    seg;
    logic [15:0]   value;
    logic [ND-1:0] dp;
    logic          frame_valid;
    logic          err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   fv_cnt = 0;
    int   edge_cnt = 0;
    exp_t q[$];

    // reference model state
    int          run;
    logic [3:0]  last_en;
    logic [7:0]  last_seg;
    logic [3:0]  m_nib [ND];
    logic [3:0]  m_dp;
    logic [3:0]  m_cap;
    logic        m_err;
    logic [3:0]  pend_en;
    logic [7:0]  pend_seg;
    logic        rst_at_edge = 1'b1;

    // monitor state
    logic [15:0] last_v;
    logic [3:0]  last_d;
    logic        last_e;
    logic        prev_fv;

    seg7_scan_decoder #(.NDIGITS(ND), .STABLE(STB)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_en    (digit_en),
        .seg         (seg),
        .value       (value),
        .dp          (dp),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        int r = -1;
        for (int i = 0; i < 16; i++) if (TB_PAT[i] == p) r = i;
        return r;
    endfunction

    // One FSM decision: a digit is captured when its unbroken run of identical
    // one-hot samples reaches exactly STB.
    task automatic model_step(input logic [3:0] en, input logic [7:0] sg, input int e_no);
        exp_t x;
        int   h;
        if (en == 4'b0) begin
            run = 0;
        end else if ($countones(en) != 1) begin
            run   = 0;
            m_err = 1'b1;
        end else begin
            if (run != 0 && en == last_en && sg == last_seg) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            if (run == int'(STB)) begin
                h = decode(sg[6:0]);
                for (int i = 0; i < int'(ND); i++) begin
                    if (en[i]) begin
                        m_nib[i] = (h < 0) ? 4'h0 : 4'(h);
                        m_dp[i]  = ~sg[7];
                        m_cap[i] = 1'b1;
                    end
                end
                if (h < 0) m_err = 1'b1;
                if (m_cap == 4'hF) begin
                    for (int i = 0; i < int'(ND); i++) x.v[4*i +: 4] = m_nib[i];
                    x.d       = m_dp;
                    x.e       = m_err;
                    x.edge_no = e_no;
                    q.push_back(x);
                    m_cap = 4'h0;
                    m_err = 1'b0;
                end
            end
        end
        last_en  = en;
        last_seg = sg;
    endtask

    // Model runs one sample behind the ports, matching the input register.
    always @(posedge clk) begin
        if (reset) begin
            run      = 0;
            m_cap    = 4'h0;
            m_err    = 1'b0;
            m_dp     = 4'h0;
            for (int i = 0; i < int'(ND); i++) m_nib[i] = 4'h0;
            last_en  = 4'h0;
            last_seg = 8'h0;
            pend_en  = 4'h0;
            pend_seg = 8'h0;
        end else begin
            model_step(pend_en, pend_seg, edge_cnt);
            pend_en  = digit_en;
            pend_seg = seg;
        end
        rst_at_edge = reset;
    end

    // Monitor: compare each pulse against the scoreboard, and check outputs hold otherwise.
    always @(negedge clk) begin
        exp_t x;
        if (rst_at_edge) begin
            chk("rst_value", 32'(value), 32'h0);
            chk("rst_dp", 32'(dp), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
            chk("rst_fv", 32'(frame_valid), 32'h0);
            last_v  = 16'h0;
            last_d  = 4'h0;
            last_e  = 1'b0;
            prev_fv = 1'b0;
        end else if (frame_valid) begin
            fv_cnt++;
            chk("fv_back_to_back", 32'(prev_fv), 32'h0);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame: got value %h, required no pulse (t=%0t)", value, $time);
                last_v = value;
                last_d = dp;
                last_e = err;
            end else begin
                x = q.pop_front();
                chk("frame_value", 32'(value), 32'(x.v));
                chk("frame_dp", 32'(dp), 32'(x.d));
                chk("frame_err", 32'(err), 32'(x.e));
                chk("frame_latency", 32'(edge_cnt - 1), 32'(x.edge_no));
                last_v = x.v;
                last_d = x.d;
                last_e = x.e;
            end
            prev_fv = 1'b1;
        end else begin
            chk("hold_value", 32'(value), 32'(last_v));
            chk("hold_dp", 32'(dp), 32'(last_d));
            chk("hold_err", 32'(err), 32'(last_e));
            prev_fv = 1'b0;
        end
    end

    task automatic hold(input logic [3:0] en, input logic [7:0] sg, input int n);
        digit_en = en;
        seg      = sg;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input int h, input bit dp_on, input int n);
        hold(4'(1 << d), {~dp_on, TB_PAT[h]}, n);
    endtask

    task automatic expect_frame(input string name, input logic [15:0] v, input logic [3:0] d,
                                input logic e, input int pulses, input int base);
        hold(4'h0, 8'hFF, 4);
        chk({name, "_value"}, 32'(value), 32'(v));
        chk({name, "_dp"}, 32'(dp), 32'(d));
        chk({name, "_err"}, 32'(err), 32'(e));
        chk({name, "_pulses"}, 32'(fv_cnt - base), 32'(pulses));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base;
        logic [3:0]  mh;
        int          sel;
        logic [6:0]  pat;

        reset    = 1'b1;
        digit_en = 4'h0;
        seg      = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(4'h0, 8'hFF, 2);

        // digits 0..3, no DP
        base = fv_cnt;
        for (int i = 0; i < 4; i++) show(i, i, 1'b0, 4);
        expect_frame("s1", 16'h3210, 4'b0000, 1'b0, 1, base);

        // A..D with DP lit on digit 2
        base = fv_cnt;
        for (int i = 0; i < 4; i++) show(i, 10 + i, (i == 2), 4);
        expect_frame("s2", 16'hDCBA, 4'b0100, 1'b0, 1, base);

        // blank pattern on digit 1, then a clean frame
        base = fv_cnt;
        show(0, 5, 1'b0, 4);
        hold(4'b0010, 8'hFF, 4);
        show(2, 6, 1'b0, 4);
        show(3, 7, 1'b0, 4);
        expect_frame("s3a", 16'h7605, 4'b0000, 1'b1, 1, base);
        base = fv_cnt;
        for (int i = 0; i < 4; i++) show(i, i + 1, 1'b0, 4);
        expect_frame("s3b", 16'h4321, 4'b0000, 1'b0, 1, base);

        // short dwell on digit 0 and a one-cycle multi-hot strobe
        base = fv_cnt;
        show(0, 9, 1'b0, 2);
        hold(4'b0011, 8'hC0, 1);
        for (int i = 1; i < 4; i++) show(i, i, 1'b0, 4);
        chk("s4_no_early_pulse", 32'(fv_cnt - base), 32'h0);
        show(0, 8, 1'b0, 4);
        expect_frame("s4", 16'h3218, 4'b0000, 1'b1, 1, base);

        // reset after three of four digits
        base = fv_cnt;
        for (int i = 0; i < 3; i++) show(i, 9, 1'b0, 4);
        hold(4'h0, 8'hFF, 1);
        reset = 1'b1;
        hold(4'h0, 8'hFF, 2);
        chk("s5_in_reset_value", 32'(value), 32'h0);
        chk("s5_in_reset_pulses", 32'(fv_cnt - base), 32'h0);
        reset = 1'b0;
        hold(4'h0, 8'hFF, 2);
        for (int i = 0; i < 3; i++) show(i, 4 + i, 1'b0, 4);
        // digit 3 then held long after completion
        show(3, 7, 1'b0, 54);
        chk("s6_hold_pulses", 32'(fv_cnt - base), 32'h1);
        chk("s6_hold_value", 32'(value), 32'h7654);
        for (int i = 0; i < 3; i++) show(i, 0, 1'b0, 4);
        chk("s6_partial_pulses", 32'(fv_cnt - base), 32'h1);
        show(3, 15, 1'b0, 4);
        expect_frame("s6", 16'hF000, 4'b0000, 1'b0, 2, base);

        // randomized scanning
        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 5) begin
                mh = 4'b0011 << $urandom_range(0, 2);
                hold(mh, 8'(seg), 1);
            end else if (sel < 12) begin
                hold(4'h0, 8'hFF, int'($urandom_range(1, 3)));
            end else if (sel < 14) begin
                reset = 1'b1;
                hold(4'(1 << $urandom_range(0, 3)), 8'hFF, 2);
                reset = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) pat = 7'($urandom);
                else                           pat = TB_PAT[$urandom_range(0, 15)];
                hold(4'(1 << $urandom_range(0, 3)), {1'($urandom), pat},
                     int'($urandom_range(1, 6)));
            end
        end

        hold(4'h0, 8'hFF, 6);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
